load_data: RTL
==============

Name: load_data

Overview:
- Input-side loader for the in-place radix-2 FFT.
- Accepts a frame of N complex samples over a valid/ready receive handshake and writes each sample into one of two single-port memory banks.
- Sample index k goes to bank (^k), word address k[R-2:0]. This is the same bank/address mapping the output-side reader uses.
- Started by the FFT controller. Reports completion with a one-cycle done pulse.

Parameters:
- N, 32, FFT size (samples per frame); N = 2**R
- R, 5, index width log2(N); bank address width is R-1
- DW, 16, width of each real/imag component; a sample is 2*DW bits {re, im}

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_LD_en  input  1  FFT controller start request; sampled only in ST_IDLE
- o_LD_done  output  1  one-cycle pulse when the last sample of the frame has been written
- i_rx_valid  input  1  upstream sample valid
- i_rx_data  input  2*DW  upstream sample {re, im}
- o_rx_ready  output  1  loader ready; a transfer occurs when i_rx_valid && o_rx_ready
- o_m0_w_en  output  1  bank0 write enable
- o_m0_addr  output  R-1  bank0 word address
- o_m0_w_data  output  2*DW  bank0 write data
- o_m1_w_en  output  1  bank1 write enable
- o_m1_addr  output  R-1  bank1 word address
- o_m1_w_data  output  2*DW  bank1 write data

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high on i_clk.
- Reset values:
  - All outputs 0.
  - State ST_IDLE; sample counter r_cnt (R bits) = 0.
  - Reset mid-frame abandons the frame. No write is issued on the reset cycle or after it.
- All outputs are registered.
- Write index w_idx = r_cnt (see Optional Feature).
- Bank select: b = ^w_idx (XOR-reduce of all R bits).
  - b = 0 -> bank0.
  - b = 1 -> bank1.
- Word address = w_idx[R-2:0].
- States:
  - ST_IDLE:
    - o_rx_ready = 0.
    - If i_LD_en: o_rx_ready <= 1, go to ST_RX.
  - ST_RX (wait for transfer):
    - On i_rx_valid && o_rx_ready: write to bank b.
      - o_mb_w_en <= 1, o_mb_addr <= w_idx[R-2:0], o_mb_w_data <= i_rx_data.
      - o_rx_ready <= 0; go to ST_WRITE.
    - Otherwise hold; o_rx_ready stays 1.
  - ST_WRITE:
    - Both w_en <= 0.
    - If r_cnt == N-1: r_cnt <= 0, o_LD_done <= 1, go to ST_DONE.
    - Else: r_cnt <= r_cnt + 1, o_rx_ready <= 1, go to ST_RX.
  - ST_DONE:
    - o_LD_done <= 0; go to ST_IDLE.
  - Unused encodings: go to ST_IDLE.
- Throughput and latency:
  - At most one sample per 2 cycles.
  - Write enable is asserted for exactly 1 cycle, the cycle after the accepting edge.
  - Exactly one bank is enabled per write; both w_en are never high together.
- Address/data outputs of the bank not written hold their previous values.
- i_LD_en outside ST_IDLE is ignored; there is no restart mid-frame.
- i_rx_valid outside ST_RX is ignored; upstream must hold data until ready.
- Counter wraps N-1 -> 0 at frame end. A new frame always starts at index 0.
- Per frame: exactly N writes, N/2 per bank; every (bank, address) pair written once.
- The done pulse is high for exactly 1 cycle, coincident with the cycle after the final write-enable cycle.

Optional Feature:
- Macro LD_BITREV_EN.
- When defined:
  - w_idx = bit-reverse of r_cnt over R bits, using the codebase bitReverse block.
  - Bank select and address are derived from the reversed index.
  - Memory holds the frame in bit-reversed order, for a natural-order-output FFT.
- When undefined: w_idx = r_cnt; no reversal logic is instantiated.
- Handshake, timing and done pulse are identical in both builds.

Test Plan:
- Reset, then pulse i_LD_en, then feed samples 0..3 with valid held high (N=32, no macro):
  - sample 0 -> bank0 addr0
  - sample 1 -> bank1 addr1
  - sample 2 -> bank1 addr2
  - sample 3 -> bank0 addr3
  - writes spaced every 2 cycles
- Full frame of 32 samples with data = index:
  - 16 writes per bank; sample 16 -> bank1 addr0; sample 31 -> bank1 addr15
  - o_LD_done pulses 1 cycle after the last write; r_cnt = 0 afterwards
- Backpressure: deassert i_rx_valid for 5 cycles mid-frame:
  - o_rx_ready stays 1, no write occurs
  - resumes at the correct next index
- i_LD_en pulsed during ST_RX:
  - no effect, frame completes at 32 samples
- i_rst asserted after sample 10:
  - all outputs 0 next cycle
  - a new i_LD_en starts at index 0 -> bank0 addr0
- With LD_BITREV_EN:
  - sample 1 (reversed 10000) -> bank1 addr0
  - sample 3 (reversed 11000) -> bank0 addr8
  - done timing unchanged

Source files
------------

// File: rtl/load_data.sv
// Input-side loader for the in-place radix-2 FFT: writes a frame of N samples into two banks.
// Optional build macro LD_BITREV_EN stores the frame in bit-reversed index order.
//
// state    | meaning
// ST_IDLE  | waiting for i_LD_en from the FFT controller
// ST_RX    | rx_ready high, waiting for a sample transfer
// ST_WRITE | bank write enable high for the accepted sample
// ST_DONE  | o_LD_done pulse cycle
module load_data #(
  parameter int N  = 32,
  parameter int R  = 5,
  parameter int DW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_LD_en,
  output logic            o_LD_done,
  input  logic            i_rx_valid,
  input  logic [2*DW-1:0] i_rx_data,
  output logic            o_rx_ready,
  output logic            o_m0_w_en,
  output logic [R-2:0]    o_m0_addr,
  output logic [2*DW-1:0] o_m0_w_data,
  output logic            o_m1_w_en,
  output logic [R-2:0]    o_m1_addr,
  output logic [2*DW-1:0] o_m1_w_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_WRITE, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic [R-1:0]    r_cnt, cnt_nxt;
  logic [R-1:0]    w_idx;
  logic            w_bank;
  logic            ready_nxt, done_nxt;
  logic            m0_w_en_nxt, m1_w_en_nxt;
  logic [R-2:0]    m0_addr_nxt, m1_addr_nxt;
  logic [2*DW-1:0] m0_w_data_nxt, m1_w_data_nxt;

`ifdef LD_BITREV_EN
  // bitReverse: index bit i comes from counter bit R-1-i
  for (genvar gi = 0; gi < R; gi++) begin : g_bit_reverse
    assign w_idx[gi] = r_cnt[R-1-gi];
  end
`else
  assign w_idx = r_cnt;
`endif

  assign w_bank = ^w_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      r_cnt       <= '0;
      o_rx_ready  <= 1'b0;
      o_LD_done   <= 1'b0;
      o_m0_w_en   <= 1'b0;
      o_m0_addr   <= '0;
      o_m0_w_data <= '0;
      o_m1_w_en   <= 1'b0;
      o_m1_addr   <= '0;
      o_m1_w_data <= '0;
    end else begin
      state       <= state_nxt;
      r_cnt       <= cnt_nxt;
      o_rx_ready  <= ready_nxt;
      o_LD_done   <= done_nxt;
      o_m0_w_en   <= m0_w_en_nxt;
      o_m0_addr   <= m0_addr_nxt;
      o_m0_w_data <= m0_w_data_nxt;
      o_m1_w_en   <= m1_w_en_nxt;
      o_m1_addr   <= m1_addr_nxt;
      o_m1_w_data <= m1_w_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = r_cnt;
    ready_nxt     = o_rx_ready;
    done_nxt      = o_LD_done;
    m0_w_en_nxt   = o_m0_w_en;
    m0_addr_nxt   = o_m0_addr;
    m0_w_data_nxt = o_m0_w_data;
    m1_w_en_nxt   = o_m1_w_en;
    m1_addr_nxt   = o_m1_addr;
    m1_w_data_nxt = o_m1_w_data;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b0;
        if (i_LD_en) begin
          ready_nxt = 1'b1;
          state_nxt = ST_RX;
        end
      end
      ST_RX: begin
        if (i_rx_valid && o_rx_ready) begin
          if (w_bank) begin
            m1_w_en_nxt   = 1'b1;
            m1_addr_nxt   = w_idx[R-2:0];
            m1_w_data_nxt = i_rx_data;
          end else begin
            m0_w_en_nxt   = 1'b1;
            m0_addr_nxt   = w_idx[R-2:0];
            m0_w_data_nxt = i_rx_data;
          end
          ready_nxt = 1'b0;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        m0_w_en_nxt = 1'b0;
        m1_w_en_nxt = 1'b0;
        if (r_cnt == R'(N-1)) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt   = r_cnt + {{(R-1){1'b0}}, 1'b1};
          ready_nxt = 1'b1;
          state_nxt = ST_RX;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
